// File: rtl/mole_round_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mole_round_timer
//  Purpose  : Runs one whack-a-mole round for the game FSM. It picks a random
//             hole, lights it, times the player's reaction in milliseconds,
//             scores the round as a hit or a miss, and hands back a 1-cycle
//             completion pulse together with the running saturating score.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             play_flag, new_mole   - FSM PLAY level / round request pulse
//             buttons[NUM_HOLES]    - synchronised player buttons (active high)
//             mole_onehot           - lit hole, zero when no mole is up
//             mole_complete         - round resolved pulse
//             hit_pulse/miss_pulse  - outcome pulses, coincident with complete
//             score[12]             - accumulated score, saturates at 4095
//             last_rt_ms[16]        - last reaction time, timeout after a miss
//  Revision : 1.0 - initial release
// ============================================================================
module mole_round_timer #(
   parameter int CLKS_PER_MS     = 50000,
   parameter int MOLE_TIMEOUT_MS = 1000,
   parameter int NUM_HOLES       = 8,
   parameter int PTS_SHIFT       = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 play_flag,
   input  logic                 new_mole,
   input  logic [NUM_HOLES-1:0] buttons,
   output logic [NUM_HOLES-1:0] mole_onehot,
   output logic                 mole_complete,
   output logic                 hit_pulse,
   output logic                 miss_pulse,
   output logic [11:0]          score,
   output logic [15:0]          last_rt_ms
);

   localparam int c_hole_w = $clog2(NUM_HOLES);
   localparam int c_pre_w  = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [c_pre_w-1:0]   c_pre_max = c_pre_w'(CLKS_PER_MS - 1);
   localparam logic [15:0]          c_timeout = 16'(MOLE_TIMEOUT_MS);
   localparam logic [NUM_HOLES-1:0] c_one     = {{(NUM_HOLES-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_RESOLVE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nx;
   logic [15:0]           r_lfsr;
   logic [NUM_HOLES-1:0]  r_btn_q;
   logic                  r_play_q;
   logic [c_pre_w-1:0]    r_prescale;
   logic [15:0]           r_ms_cnt;
   logic [15:0]           r_rt_ms;
   logic                  r_hit;
   logic [c_hole_w-1:0]   r_prev_hole;

   logic [NUM_HOLES-1:0]  w_btn_edge;
   logic                  w_lit_edge;
   logic                  w_timeout;
   logic [c_hole_w-1:0]   w_hole_raw;
   logic [c_hole_w-1:0]   w_hole_pick;
   logic [15:0]           w_lfsr_nx;
   logic [15:0]           w_pts;
   logic [16:0]           w_sum;
   logic [11:0]           w_score_sat;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
   assign w_lfsr_nx = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

   // Rising edges only: a button already held when the mole lights never hits.
   assign w_btn_edge = buttons & ~r_btn_q;
   assign w_lit_edge = |(w_btn_edge & mole_onehot);
   assign w_timeout  = (r_ms_cnt == c_timeout);

   // Never light the same hole twice in a row; NUM_HOLES is a power of two so
   // the increment wraps naturally.
   assign w_hole_raw  = r_lfsr[c_hole_w-1:0];
   assign w_hole_pick = (w_hole_raw == r_prev_hole) ? w_hole_raw + c_hole_w'(1) : w_hole_raw;

   // rt_ms never exceeds the timeout, so the subtraction cannot underflow.
   // The sum is kept wide enough that a large point value still clamps.
   assign w_pts       = 16'd1 + ((c_timeout - r_rt_ms) >> PTS_SHIFT);
   assign w_sum       = {5'd0, score} + {1'b0, w_pts};
   assign w_score_sat = (w_sum > 17'd4095) ? 12'hFFF : w_sum[11:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (new_mole && play_flag) w_state_nx = S_ARMED;
         end
         S_ARMED: begin
            if (!play_flag)                    w_state_nx = S_IDLE;
            else if (w_lit_edge || w_timeout)  w_state_nx = S_RESOLVE;
         end
         S_RESOLVE: w_state_nx = S_IDLE;
         default:   w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr        <= 16'hACE1;
         r_btn_q       <= '0;
         r_play_q      <= 1'b0;
         r_prescale    <= '0;
         r_ms_cnt      <= '0;
         r_rt_ms       <= '0;
         r_hit         <= 1'b0;
         r_prev_hole   <= '0;
         mole_onehot   <= '0;
         mole_complete <= 1'b0;
         hit_pulse     <= 1'b0;
         miss_pulse    <= 1'b0;
         score         <= '0;
         last_rt_ms    <= '0;
      end else begin
         r_lfsr        <= w_lfsr_nx;
         r_btn_q       <= buttons;
         r_play_q      <= play_flag;
         mole_complete <= 1'b0;
         hit_pulse     <= 1'b0;
         miss_pulse    <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_state_nx == S_ARMED) begin
                  mole_onehot <= c_one << w_hole_pick;
                  r_prev_hole <= w_hole_pick;
                  r_ms_cnt    <= '0;
                  r_prescale  <= '0;
               end
            end
            S_ARMED: begin
               if (w_state_nx == S_IDLE) begin
                  mole_onehot <= '0;
               end else if (w_state_nx == S_RESOLVE) begin
                  // Hit has priority over a coincident timeout.
                  r_hit   <= w_lit_edge;
                  r_rt_ms <= r_ms_cnt;
               end else if (r_prescale == c_pre_max) begin
                  r_prescale <= '0;
                  r_ms_cnt   <= r_ms_cnt + 16'd1;
               end else begin
                  r_prescale <= r_prescale + c_pre_w'(1);
               end
            end
            S_RESOLVE: begin
               mole_onehot <= '0;
               // Dropping play_flag here aborts the round silently.
               if (play_flag) begin
                  mole_complete <= 1'b1;
                  hit_pulse     <= r_hit;
                  miss_pulse    <= ~r_hit;
                  if (r_hit) begin
                     score      <= w_score_sat;
                     last_rt_ms <= r_rt_ms;
                  end else begin
                     last_rt_ms <= c_timeout;
                  end
               end
            end
            default: mole_onehot <= '0;
         endcase

         // A new game starts from zero.
         if (play_flag && !r_play_q) begin
            score      <= '0;
            last_rt_ms <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mole_round_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mole_round_timer
//  Purpose  : Self-checking bench for mole_round_timer with small timing
//             parameters. Each round pushes its predicted outcome to a queue;
//             a monitor pops and compares on every mole_complete.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mole_round_timer;

   localparam int CLKS    = 4;
   localparam int TMO     = 20;
   localparam int HOLES   = 8;
   localparam int SHIFT   = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             play_flag;
   logic             new_mole;
   logic [HOLES-1:0] buttons;
   logic [HOLES-1:0] mole_onehot;
   logic             mole_complete;
   logic             hit_pulse;
   logic             miss_pulse;
   logic [11:0]      score;
   logic [15:0]      last_rt_ms;

   mole_round_timer #(
      .CLKS_PER_MS     (CLKS),
      .MOLE_TIMEOUT_MS (TMO),
      .NUM_HOLES       (HOLES),
      .PTS_SHIFT       (SHIFT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .play_flag     (play_flag),
      .new_mole      (new_mole),
      .buttons       (buttons),
      .mole_onehot   (mole_onehot),
      .mole_complete (mole_complete),
      .hit_pulse     (hit_pulse),
      .miss_pulse    (miss_pulse),
      .score         (score),
      .last_rt_ms    (last_rt_ms)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hit;
      logic [11:0] score;
      logic [15:0] rt;
   } exp_t;

   // mode: 0 press lit button, 1 press a wrong button, 2 no press,
   //       3 all buttons held from before new_mole
   typedef struct {
      int d;
      int mode;
   } vec_t;

   exp_t             sb[$];
   int               errors = 0;
   int               checks = 0;
   int               completes = 0;
   int               m_score = 0;
   int               m_rt = 0;
   logic [HOLES-1:0] prev_lit = '0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (hit_pulse || miss_pulse) check("pulse_has_complete", int'(mole_complete), 1);
      if (mole_complete) begin
         completes++;
         if (sb.size() == 0) begin
            check("unexpected_complete", sb.size(), 1);
         end else begin
            exp_t x;
            x = sb.pop_front();
            check("hit_pulse",  int'(hit_pulse),  int'(x.hit));
            check("miss_pulse", int'(miss_pulse), int'(!x.hit));
            check("score",      int'(score),      int'(x.score));
            check("last_rt_ms", int'(last_rt_ms), int'(x.rt));
            check("onehot_off", int'(mole_onehot), 0);
         end
      end
   end

   task automatic do_round(input int d, input int mode);
      logic [HOLES-1:0] lit;
      exp_t x;
      bit   hit;
      bit   done;
      int   e;
      int   rt;
      if (mode == 3) buttons = '1;
      new_mole = 1'b1;
      @(posedge clk);
      #1 new_mole = 1'b0;
      lit = mole_onehot;
      check("onehot_valid", $countones(lit), 1);
      if (prev_lit != '0) check("hole_repeat", int'(lit == prev_lit), 0);
      prev_lit = lit;

      hit = (mode == 0) && (d <= CLKS * TMO);
      rt  = hit ? d / CLKS : TMO;
      if (hit) begin
         m_score = m_score + 1 + ((TMO - rt) >> SHIFT);
         if (m_score > 4095) m_score = 4095;
      end
      m_rt    = rt;
      x.hit   = hit;
      x.score = 12'(m_score);
      x.rt    = 16'(rt);
      sb.push_back(x);

      done = 1'b0;
      e    = 0;
      while (!done && e < 120) begin
         e++;
         if (e == d + 1) begin
            if (mode == 0) buttons = lit;
            if (mode == 1) buttons = {lit[HOLES-2:0], lit[HOLES-1]};
         end
         @(posedge clk);
         @(negedge clk);
         if (mole_complete) done = 1'b1;
      end
      check("complete_seen", int'(done), 1);
      check("latency", e, hit ? d + 2 : CLKS * TMO + 2);
      buttons = '0;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      vecs[0] = '{20, 0};   // reaction 5 ms, +4
      vecs[1] = '{81, 0};   // press one cycle too late: miss
      vecs[2] = '{80, 0};   // press on the timeout cycle: hit wins, +1
      vecs[3] = '{0,  0};   // immediate, +6
      vecs[4] = '{3,  0};   // last cycle of ms 0, +6
      vecs[5] = '{4,  0};   // first cycle of ms 1, +5
      vecs[6] = '{10, 1};   // wrong hole only: miss
      vecs[7] = '{0,  3};   // pre-held buttons: miss
      vecs[8] = '{0,  2};   // no press: miss
      vecs[9] = '{47, 0};   // reaction 11 ms, +3

      rst_n = 1'b0; play_flag = 1'b0; new_mole = 1'b0; buttons = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_onehot",   int'(mole_onehot),   0);
      check("rst_complete", int'(mole_complete), 0);
      check("rst_score",    int'(score),         0);
      check("rst_rt",       int'(last_rt_ms),    0);
      rst_n = 1'b1;
      play_flag = 1'b1;
      @(posedge clk);
      #1;

      // new_mole without play_flag is ignored.
      play_flag = 1'b0; new_mole = 1'b1;
      @(posedge clk);
      #1 new_mole = 1'b0;
      check("ignored_no_play", int'(mole_onehot), 0);
      play_flag = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) do_round(vecs[i].d, vecs[i].mode);
      check("table_score", int'(score), 25);

      // Asynchronous reset mid-round.
      new_mole = 1'b1;
      @(posedge clk);
      #1 new_mole = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_onehot", int'(mole_onehot), 0);
      check("arst_score",  int'(score),       0);
      check("arst_rt",     int'(last_rt_ms),  0);
      rst_n = 1'b1;
      m_score = 0; m_rt = 0; prev_lit = '0;
      @(posedge clk);
      #1;
      do_round(20, 0);
      check("post_rst_score", int'(score), 4);

      // Abort mid-round, then restart the game.
      new_mole = 1'b1;
      @(posedge clk);
      #1 new_mole = 1'b0;
      prev_lit = mole_onehot;
      repeat (6) @(posedge clk);
      #1 play_flag = 1'b0;
      c0 = completes;
      @(posedge clk);
      #1;
      check("abort_onehot", int'(mole_onehot), 0);
      repeat (100) @(posedge clk);
      #1;
      check("abort_no_complete", completes, c0);
      check("abort_score", int'(score), m_score);
      check("abort_rt",    int'(last_rt_ms), m_rt);
      play_flag = 1'b1;
      @(posedge clk);
      #1;
      check("restart_score", int'(score), 0);
      check("restart_rt",    int'(last_rt_ms), 0);
      m_score = 0; m_rt = 0;

      repeat (50) do_round(0, 0);

      // Climb to 4093 exactly, then saturate.
      while (m_score < 4093) begin
         int need;
         need = 4093 - m_score;
         if (need >= 6) do_round(0, 0);
         else           do_round(CLKS * (TMO - 4 * (need - 1)), 0);
      end
      check("score_4093", int'(score), 4093);
      do_round(0, 0);
      check("sat_first",  int'(score), 4095);
      do_round(0, 0);
      check("sat_second", int'(score), 4095);
      check("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
